adder_arbiter: RTL and testbench

Shares one registered W-bit adder among NREQ requesters. Each requester presents operand pairs through a valid/ready handshake, and a round-robin arbiter grants one requester at a time. The block returns the sum, the carry and the requester ID on a single result port with its own valid/ready handshake. It sits between the project's input pin decode and the `uo_out` driver, replacing the free-running combinational adder with a sequenced, shared one.

---
 rtl/adder_arb_pkg.sv | 13 +
 rtl/adder_arbiter_rr_arbiter.sv | 34 +++
 rtl/adder_arbiter.sv | 179 +++++++++++++++++
 tb/tb_adder_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and default sizing for the shared-adder arbiter.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int NREQ_DEF = 4;
  localparam int W_DEF    = 8;

endpackage

// File: rtl/adder_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: highest priority goes to index ptr,
// then ptr+1 upward with wrap.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic [IDW-1:0] w_idx;

  // Scan from the farthest slot back to ptr so the nearest requester wins.
  always_comb begin
    w_idx   = {IDW{1'b0}};
    gnt_idx = {IDW{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = IDW'((int'(ptr) + k) % NREQ);
      if (req[w_idx]) begin
        gnt_idx = w_idx;
      end else begin
        gnt_idx = gnt_idx;
      end
    end
    if (|req) begin
      gnt = {{(NREQ-1){1'b0}}, 1'b1} << gnt_idx;
    end else begin
      gnt = {NREQ{1'b0}};
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// One registered adder shared by NREQ requesters under round-robin arbitration.
// Define ADDER_ARB_SAT_EN to saturate the sum instead of wrapping it.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [W-1:0]      res_sum,
  output logic              res_carry,
  output logic [IDW-1:0]    res_id
);

  arb_state_t     r_state;
  arb_state_t     w_state_next;
  logic [IDW-1:0] r_ptr;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [IDW-1:0] r_id;
  logic [W-1:0]   r_sum;
  logic           r_carry;
  logic [IDW-1:0] r_res_id;
  logic           r_res_valid;

  logic [NREQ-1:0] w_gnt;
  logic [IDW-1:0]  w_gnt_idx;
  logic [IDW-1:0]  w_ptr_next;
  logic [W-1:0]    w_sel_a;
  logic [W-1:0]    w_sel_b;
  logic [W:0]      w_sum_full;
  logic [W-1:0]    w_sum;
  logic            w_carry;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  // Grant is offered only while idle; the arbiter output is don't-care otherwise.
  always_comb begin
    req_ready = {NREQ{1'b0}};
    if (r_state == IDLE) begin
      req_ready = w_gnt;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // One-hot operand mux keeps every part-select index constant.
  always_comb begin
    w_sel_a = {W{1'b0}};
    w_sel_b = {W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_a = w_sel_a | req_a[i*W +: W];
        w_sel_b = w_sel_b | req_b[i*W +: W];
      end else begin
        w_sel_a = w_sel_a;
        w_sel_b = w_sel_b;
      end
    end
  end

  // Pointer moves to the slot just after the winner.
  always_comb begin
    w_ptr_next = {IDW{1'b0}};
    if (w_gnt_idx == IDW'(NREQ - 1)) begin
      w_ptr_next = {IDW{1'b0}};
    end else begin
      w_ptr_next = w_gnt_idx + {{(IDW-1){1'b0}}, 1'b1};
    end
  end

  // Unsigned add; saturating build clamps to all-ones and flags it in carry.
  always_comb begin
    w_sum_full = {1'b0, r_a} + {1'b0, r_b};
`ifdef ADDER_ARB_SAT_EN
    if (w_sum_full[W]) begin
      w_sum   = {W{1'b1}};
      w_carry = 1'b1;
    end else begin
      w_sum   = w_sum_full[W-1:0];
      w_carry = 1'b0;
    end
`else
    w_sum   = w_sum_full[W-1:0];
    w_carry = w_sum_full[W];
`endif
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (|req_valid) begin
          w_state_next = EXEC;
        end else begin
          w_state_next = IDLE;
        end
      end
      EXEC: w_state_next = RESP;
      RESP: begin
        if (res_ready) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = RESP;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, result registers and arbitration pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= {IDW{1'b0}};
      r_a         <= {W{1'b0}};
      r_b         <= {W{1'b0}};
      r_id        <= {IDW{1'b0}};
      r_sum       <= {W{1'b0}};
      r_carry     <= 1'b0;
      r_res_id    <= {IDW{1'b0}};
      r_res_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_a   <= w_sel_a;
            r_b   <= w_sel_b;
            r_id  <= w_gnt_idx;
            r_ptr <= w_ptr_next;
          end
        end
        EXEC: begin
          r_sum       <= w_sum;
          r_carry     <= w_carry;
          r_res_id    <= r_id;
          r_res_valid <= 1'b1;
        end
        RESP: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
          end
        end
        default: r_res_valid <= 1'b0;
      endcase
    end
  end

  assign res_valid = r_res_valid;
  assign res_sum   = r_sum;
  assign res_carry = r_carry;
  assign res_id    = r_res_id;

endmodule

// File: tb/tb_adder_arbiter.sv
// Scoreboard bench for adder_arbiter: a cycle model predicts grants and
// queues expected results at acceptance; results are compared as they appear.
module tb_adder_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              res_valid;
  logic              res_ready;
  logic [W-1:0]      res_sum;
  logic              res_carry;
  logic [IDW-1:0]    res_id;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [W-1:0]   sum;
    logic           carry;
  } exp_t;

  exp_t sb[$];
  int   n_err   = 0;
  int   n_chk   = 0;
  int   cyc     = 0;
  int   m_state = 0;
  int   m_ptr   = 0;

  adder_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_carry (res_carry),
    .res_id    (res_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_add(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] s;
    s = {1'b0, a} + {1'b0, b};
    e.id = IDW'(id);
`ifdef ADDER_ARB_SAT_EN
    e.sum   = s[W] ? {W{1'b1}} : s[W-1:0];
    e.carry = s[W];
`else
    e.sum   = s[W-1:0];
    e.carry = s[W];
`endif
    return e;
  endfunction

  // Cycle model: predicts req_ready/res_valid and queues/retires expected results.
  always @(negedge clk) begin
    logic [NREQ-1:0] er;
    int g;
    if (rst) begin
      m_state = 0;
      m_ptr   = 0;
      sb.delete();
      chk("rst_req_ready", req_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_sum", res_sum, 0);
      chk("rst_res_carry", res_carry, 0);
      chk("rst_res_id", res_id, 0);
    end else begin
      er = '0;
      g  = -1;
      if (m_state == 0) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        end
      end
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", req_ready, er);
      chk("res_valid", res_valid, m_state == 2);
      if (m_state == 2) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 0, 1);
        end else begin
          chk("res_id", res_id, sb[0].id);
          chk("res_sum", res_sum, sb[0].sum);
          chk("res_carry", res_carry, sb[0].carry);
          if (res_ready) void'(sb.pop_front());
        end
      end
      case (m_state)
        0: if (g >= 0) begin
             sb.push_back(model_add(g, req_a[g*W +: W], req_b[g*W +: W]));
             m_ptr   = (g + 1) % NREQ;
             m_state = 1;
           end
        1: m_state = 2;
        default: if (res_ready) m_state = 0;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic wait_res(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!res_valid && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (!res_valid) chk(tag, 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_state != 0 || sb.size() != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) chk("drain_timeout", sb.size(), 0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [W-1:0]   h_sum;
    logic           h_carry;
    logic [IDW-1:0] h_id;
    int             last;
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b1;
    repeat (2) step();
    rst = 1'b0;

    // Basic add and two-cycle latency.
    set_op(0, 8'h12, 8'h34);
    req_valid = 4'b0001;
    @(negedge clk); chk("t1_grant", req_ready, 4'b0001);
    step(); req_valid = '0;
    @(negedge clk); chk("t1_lat_exec", res_valid, 0);
    step();
    @(negedge clk);
    chk("t1_valid", res_valid, 1);
    chk("t1_sum", res_sum, 8'h46);
    chk("t1_carry", res_carry, 0);
    chk("t1_id", res_id, 0);
    drain();

    // Overflow from requester 2.
    set_op(2, 8'hF0, 8'h20);
    req_valid = 4'b0100;
    @(negedge clk); chk("t2_grant", req_ready, 4'b0100);
    step(); req_valid = '0;
    wait_res("t2_timeout");
`ifdef ADDER_ARB_SAT_EN
    chk("t2_sum", res_sum, 8'hFF);
`else
    chk("t2_sum", res_sum, 8'h10);
`endif
    chk("t2_carry", res_carry, 1);
    chk("t2_id", res_id, 2);
    drain();

    // Fairness with all requesters valid.
    rst = 1'b1; step(); rst = 1'b0;
    req_a = $urandom; req_b = $urandom;
    req_valid = 4'b1111; res_ready = 1'b1;
    last = 0;
    for (int i = 0; i < 8; i++) begin
      wait_res("t3_timeout");
      chk("t3_id_seq", res_id, i % NREQ);
      if (i > 0) chk("t3_gap", cyc - last, 3);
      last = cyc;
    end
    step(); req_valid = '0;
    drain();

    // Backpressure hold.
    req_a = $urandom; req_b = $urandom;
    req_valid = 4'b1111; res_ready = 1'b0;
    wait_res("t4_timeout");
    h_sum = res_sum; h_carry = res_carry; h_id = res_id;
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 4) res_ready = 1'b1;
      @(negedge clk);
      chk("t4_hold_sum", res_sum, h_sum);
      chk("t4_hold_carry", res_carry, h_carry);
      chk("t4_hold_id", res_id, h_id);
      chk("t4_busy_ready", req_ready, 4'b0000);
    end
    step();
    @(negedge clk); chk("t4_next_grant", req_ready, 4'b0010);
    step(); req_valid = '0;
    drain();

    // Reset during EXEC discards the operation and clears the pointer.
    set_op(1, 8'h55, 8'h66);
    req_valid = 4'b0010;
    step(); req_valid = '0; rst = 1'b1;
    @(negedge clk); chk("t5_rst_valid", res_valid, 0);
    step(); rst = 1'b0;
    repeat (3) begin
      @(negedge clk); chk("t5_no_result", res_valid, 0);
      step();
    end
    req_valid = 4'b1111;
    @(negedge clk); chk("t5_from_zero", req_ready, 4'b0001);
    step(); req_valid = '0;
    drain();

    // Requester 1 pulses valid while 3 is served.
    set_op(3, 8'h0A, 8'h0B);
    req_valid = 4'b1000;
    @(negedge clk); chk("t6_grant3", req_ready, 4'b1000);
    step(); req_valid = 4'b0010;
    @(negedge clk); chk("t6_exec_ready", req_ready, 4'b0000);
    step(); req_valid = 4'b0000;
    @(negedge clk);
    chk("t6_id", res_id, 3);
    chk("t6_sum", res_sum, 8'h15);
    step();
    repeat (4) begin
      @(negedge clk);
      chk("t6_idle_ready", req_ready, 4'b0000);
      chk("t6_no_spurious", res_valid, 0);
      step();
    end
    chk("sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
